// File: rtl/led_pkg.sv
// Shared constants for the LED fade chain: data width, fader state encodings
// and saturating 8-bit helpers.
package led_pkg;

    localparam int LED_W = 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_UP      = 3'd1;
    localparam logic [2:0] ST_HOLD_HI = 3'd2;
    localparam logic [2:0] ST_DOWN    = 3'd3;
    localparam logic [2:0] ST_HOLD_LO = 3'd4;

    // The 9-bit sum keeps the carry so the ramp clamps at full scale instead of wrapping.
    function automatic logic [LED_W-1:0] sat_add(input logic [LED_W-1:0] a,
                                                 input logic [LED_W-1:0] b);
        logic [LED_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[LED_W] ? {LED_W{1'b1}} : sum[LED_W-1:0];
    endfunction

    function automatic logic [LED_W-1:0] sat_sub(input logic [LED_W-1:0] a,
                                                 input logic [LED_W-1:0] b);
        return (a <= b) ? '0 : (a - b);
    endfunction

endpackage

// File: rtl/led_pwm.sv
// PWM stage: a free-running 8-bit counter compared against the brightness level,
// with the LED pin registered one clock after the compare.
module led_pwm
    import led_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [LED_W-1:0] level,
    output logic             led
);

    logic [LED_W-1:0] pwm_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pwm_cnt <= '0;
            led     <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            led     <= (pwm_cnt < level);
        end
    end

endmodule

// File: rtl/led_fader.sv
// Triangle-wave brightness sequencer: ramps up, holds at full, ramps down,
// holds at zero, advancing only on upstream tick strobes.
module led_fader
    import led_pkg::*;
#(
    parameter int STEP       = 1,
    parameter int HOLD_TICKS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             tick,
    output logic             led,
    output logic [LED_W-1:0] level,
    output logic [2:0]       phase
);

    localparam logic [LED_W-1:0] STEP_V = LED_W'(STEP);
    localparam logic [LED_W-1:0] HOLD_V = LED_W'(HOLD_TICKS);

    logic [2:0]       state;
    logic [LED_W-1:0] hold_cnt;
    logic [LED_W-1:0] up_level;
    logic [LED_W-1:0] down_level;
    logic [LED_W-1:0] hold_next;
    logic             hold_done;

    assign up_level   = sat_add(level, STEP_V);
    assign down_level = sat_sub(level, STEP_V);
    assign hold_next  = hold_cnt + 1'b1;
    assign hold_done  = (hold_next == HOLD_V);
    assign phase      = state;

    // Dropping enable behaves like a soft reset and wins over any tick in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst || !en) begin
            state    <= ST_IDLE;
            level    <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_UP;
                end
                ST_UP: begin
                    if (tick) begin
                        level <= up_level;
                        if (up_level == {LED_W{1'b1}}) begin
                            state    <= ST_HOLD_HI;
                            hold_cnt <= '0;
                        end
                    end
                end
                ST_HOLD_HI: begin
                    if (tick) begin
                        if (hold_done) begin
                            state    <= ST_DOWN;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_next;
                        end
                    end
                end
                ST_DOWN: begin
                    if (tick) begin
                        level <= down_level;
                        if (down_level == '0) begin
                            state    <= ST_HOLD_LO;
                            hold_cnt <= '0;
                        end
                    end
                end
                ST_HOLD_LO: begin
                    if (tick) begin
                        if (hold_done) begin
                            state    <= ST_UP;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_next;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    level    <= '0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    led_pwm u_pwm (
        .clk   (clk),
        .rst   (rst),
        .level (level),
        .led   (led)
    );

endmodule

// File: doc/led_fader.md
LED_FADER -- requirements
Module: led_fader

Interface
REQ-001 Parameter STEP, default 1, brightness increment/decrement applied per tick (legal 1..255).
REQ-002 Parameter HOLD_TICKS, default 16, ticks spent at full and at zero brightness before reversing (legal 1..255).
REQ-003 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 Port rst  input  1  synchronous, active-low reset; sampled on rising clk edge only.
REQ-005 Port en  input  1  run enable; high = fade sequence active.
REQ-006 Port tick  input  1  single-cycle step strobe from the upstream counter stage (one pulse per counter wrap).
REQ-007 Port led  output  1  PWM-modulated LED drive.
REQ-008 Port level  output  8  current brightness, unsigned.
REQ-009 Port phase  output  3  current FSM state encoding, for debug/verification.

Function
REQ-010 A free-running 8-bit pwm_cnt SHALL increment every clk and wrap 255->0.
REQ-011 led SHALL be registered: led <= (pwm_cnt < level); one-clk latency from pwm_cnt/level to pin.
REQ-012 level=0 SHALL give led constantly 0; level=255 SHALL give led high 255 of every 256 clks.
REQ-013 FSM states SHALL be IDLE=0, UP=1, HOLD_HI=2, DOWN=3, HOLD_LO=4; phase reflects the registered state.
REQ-014 IDLE: level=0; en=1 moves to UP next clk; a tick in that same clk is ignored.
REQ-015 UP: on tick, level <= min(level+STEP, 255) using 9-bit sum; on the tick where the result is 255, move to HOLD_HI.
REQ-016 HOLD_HI: level held at 255; hold counter cleared on entry; after HOLD_TICKS ticks move to DOWN.
REQ-017 DOWN: on tick, level <= max(level-STEP, 0), no underflow; on the tick where the result is 0, move to HOLD_LO.
REQ-018 HOLD_LO: level held at 0; after HOLD_TICKS ticks move to UP.
REQ-019 Without tick, level and hold counter SHALL not change in any state.
REQ-020 en=0 in any state SHALL force state IDLE and level 0 at the next clk edge, overriding a simultaneous tick.
REQ-021 tick asserted for consecutive clks SHALL count as one step per clk (no edge detection inside this block).
REQ-022 STEP not dividing 255 SHALL saturate at 255/0 rather than wrap; e.g. STEP=100: 0,100,200,255.

Reset
REQ-023 rst=0 at a clk edge SHALL set state IDLE, level 0, pwm_cnt 0, hold counter 0, led 0, regardless of en/tick.
REQ-024 Reset asserted mid-ramp or mid-hold SHALL abandon the sequence; after release with en=1, the sequence restarts from UP at level 0.
REQ-025 No asynchronous reset path; rst SHALL NOT appear in any sensitivity list other than via clk.

Structure
REQ-026 State encodings and the width constant 8 SHALL live in shared package led_pkg, reused by the upstream counter stage.
REQ-027 The PWM comparator (pwm_cnt + compare + registered led) SHALL be a sub-module led_pwm with ports clk, rst, level, led.
REQ-028 FSM, saturating arithmetic and hold counter SHALL stay in led_fader; no other sub-modules.

Verification
REQ-029 rst=0 for 2 clks with en=1, tick=1 -> led=0, level=0, phase=0 throughout; first edge after release -> phase=1.
REQ-030 STEP=1, HOLD_TICKS=2, en=1, tick every clk -> level reaches 255 after 255 ticks, phase 1->2, two ticks later phase=3, level 254 on the next tick.
REQ-031 STEP=100 -> level sequence 0,100,200,255 in UP, then 155,55,0 in DOWN, phase=4 at 0.
REQ-032 level forced to 128 via sequence, tick held low for 512 clks -> led high exactly 128 of each 256-clk window, level stable.
REQ-033 en dropped to 0 during DOWN with tick=1 the same clk -> next clk phase=0, level=0; led=0 one clk later.
REQ-034 rst=0 for 1 clk during HOLD_HI -> all outputs zeroed next edge; with en=1 after release, level climbs from 0 again.
